// File: rtl/acc_reader.sv
// Row buffer between an accumulator and a byte stream: stores DEPTH two-entry rows
// and emits entry 0 then entry 1 of each row. Optional ACC_READER_ROWCNT_EN adds rows_sent.
module acc_reader #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       row_valid,
   input  logic [7:0] row_in_0,
   input  logic [7:0] row_in_1,
   output logic       row_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       overflow_err
`ifdef ACC_READER_ROWCNT_EN
   ,
   output logic [7:0] rows_sent
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SEND_LO = 2'd1;
   localparam logic [1:0] SEND_HI = 2'd2;

   logic [1:0]    state, state_next;
   logic [CW-1:0] count, count_next;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   mem [DEPTH];
   logic [15:0]   head;
   logic          push, pop;

   always_comb begin
      push       = row_valid && row_ready;
      pop        = (state == SEND_HI) && out_ready;
      count_next = count + CW'(push) - CW'(pop);
      state_next = state;
      case (state)
         IDLE:    if (push)      state_next = SEND_LO;
         SEND_LO: if (out_ready) state_next = SEND_HI;
         SEND_HI: if (out_ready) state_next = (count_next != '0) ? SEND_LO : IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // row_ready is a registered view of the post-update occupancy, so a pop never frees a slot in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         row_ready    <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         row_ready <= (count_next < DEPTH_C);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (row_valid && !row_ready) overflow_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {row_in_1, row_in_0};
   end

   assign head = mem[rd_ptr];

   always_comb begin
      out_data = '0;
      case (state)
         SEND_LO: out_data = head[7:0];
         SEND_HI: out_data = head[15:8];
         default: out_data = '0;
      endcase
   end

   assign out_valid = (state != IDLE);
   assign out_last  = (state == SEND_HI);

`ifdef ACC_READER_ROWCNT_EN
   always_ff @(posedge clk) begin
      if (reset)    rows_sent <= '0;
      else if (pop) rows_sent <= rows_sent + 8'd1;
   end
`endif

endmodule

// File: tb/tb_acc_reader.sv
// Bench for acc_reader: directed scenarios plus random traffic against an element-queue model.
module tb_acc_reader;
   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       row_valid = 1'b0;
   logic [7:0] row_in_0 = '0;
   logic [7:0] row_in_1 = '0;
   logic       row_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;
   logic       overflow_err;
`ifdef ACC_READER_ROWCNT_EN
   logic [7:0] rows_sent;
`endif

   int checks = 0;
   int failures = 0;

   // model: expected element stream {last, data}; a row stays stored until its last element leaves
   logic [8:0] q[$];
   bit         m_rr;
   bit         m_ovf;
   logic [7:0] m_sent;

   always #5 clk = ~clk;

   acc_reader #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .row_valid    (row_valid),
      .row_in_0     (row_in_0),
      .row_in_1     (row_in_1),
      .row_ready    (row_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .overflow_err (overflow_err)
`ifdef ACC_READER_ROWCNT_EN
      ,
      .rows_sent    (rows_sent)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit rv, input logic [7:0] a, input logic [7:0] b, input bit ordy);
      int rows;
      row_valid = rv;
      row_in_0  = a;
      row_in_1  = b;
      out_ready = ordy;
      #1;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("row_ready", 32'(row_ready), 32'(m_rr));
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
      if (q.size() > 0) begin
         chk("out_data", 32'(out_data), 32'(q[0][7:0]));
         chk("out_last", 32'(out_last), 32'(q[0][8]));
      end
`ifdef ACC_READER_ROWCNT_EN
      chk("rows_sent", 32'(rows_sent), 32'(m_sent));
`endif
      if (q.size() > 0 && ordy) begin
         if (q[0][8]) m_sent = m_sent + 8'd1;
         void'(q.pop_front());
      end
      if (rv) begin
         if (m_rr) begin
            q.push_back({1'b0, a});
            q.push_back({1'b1, b});
         end else begin
            m_ovf = 1'b1;
         end
      end
      rows = (q.size() + 1) / 2;
      m_rr = (rows < DEPTH);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, ordy);
   endtask

   task automatic do_reset(input bit rv);
      reset     = 1'b1;
      row_valid = rv;
      row_in_0  = 8'($urandom);
      row_in_1  = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_last", 32'(out_last), 32'(0));
      chk("rst_out_data", 32'(out_data), 32'(0));
      chk("rst_overflow", 32'(overflow_err), 32'(0));
      chk("rst_row_ready", 32'(row_ready), 32'(0));
`ifdef ACC_READER_ROWCNT_EN
      chk("rst_rows_sent", 32'(rows_sent), 32'(0));
`endif
      @(posedge clk);
      @(negedge clk);
      chk("rst_overflow_hold", 32'(overflow_err), 32'(0));
      reset     = 1'b0;
      row_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      q.delete();
      m_rr   = 1'b1;
      m_ovf  = 1'b0;
      m_sent = 8'd0;
   endtask

   initial begin
      do_reset(1'b0);

      // single row
      cycle(1'b1, 8'h12, 8'h34, 1'b1);
      idle(4, 1'b1);

      // two back-to-back rows, contiguous stream
      cycle(1'b1, 8'h01, 8'h02, 1'b1);
      cycle(1'b1, 8'h03, 8'h04, 1'b1);
      idle(6, 1'b1);

      // stalls while streaming a row containing a zero
      cycle(1'b1, 8'h00, 8'hFF, 1'b0);
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 8'h00, 1'b0);
      idle(2, 1'b1);

      // fill, overflow, drain
      cycle(1'b1, 8'h01, 8'h02, 1'b0);
      cycle(1'b1, 8'h03, 8'h04, 1'b0);
      cycle(1'b1, 8'hAA, 8'hBB, 1'b0);
      idle(2, 1'b0);
      idle(7, 1'b1);

      // reset while the head row is half sent
      cycle(1'b1, 8'h55, 8'h66, 1'b1);
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 8'h00, 1'b0);
      chk("pre_rst_hi_last", 32'(out_last), 32'(1));
      do_reset(1'b1);
      idle(3, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));
      idle(8, 1'b1);

`ifdef ACC_READER_ROWCNT_EN
      do_reset(1'b0);
      for (int i = 0; i < 257; i++) begin
         cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
         cycle(1'b0, 8'h00, 8'h00, 1'b1);
      end
      idle(3, 1'b1);
      chk("rows_sent_wrap", 32'(rows_sent), 32'(1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/acc_reader.md
ACC_READER -- requirements
Module: acc_reader

Interface
REQ-001 SHALL have parameter DEPTH, 2, number of buffered rows (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port row_valid  input  1  accumulator row-complete strobe (driven from accumulator full flag).
REQ-005 SHALL have ports row_in_0 / row_in_1  input  8 each  accumulated row entries 0 and 1.
REQ-006 SHALL have port row_ready  output  1  reader can accept a row this cycle.
REQ-007 SHALL have port out_data  output  8  current streamed element.
REQ-008 SHALL have port out_valid  output  1  out_data is valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-010 SHALL have port out_last  output  1  out_data is entry 1 (last) of its row.
REQ-011 SHALL have port overflow_err  output  1  sticky: row offered while row_ready=0.

Function
REQ-012 Row accepted on rising edge when row_valid=1 and row_ready=1; {row_in_1,row_in_0} written at write pointer; write pointer increments modulo DEPTH.
REQ-013 row_ready SHALL be registered, =1 iff stored row count < DEPTH; no same-cycle bypass (full + pop still gives row_ready=0 that cycle, 1 the next).
REQ-014 Output FSM states: IDLE (no rows stored), SEND_LO (head entry 0 presented), SEND_HI (head entry 1 presented).
REQ-015 IDLE->SEND_LO on cycle after first row accepted (push-to-out_valid latency 1 cycle).
REQ-016 SEND_LO->SEND_HI on out_valid&&out_ready; out_data=row_in_0 of head, out_last=0.
REQ-017 SEND_HI on out_valid&&out_ready: pop head, read pointer +1 modulo DEPTH; ->SEND_LO if another row stored after pop, else ->IDLE; out_data=row_in_1 of head, out_last=1.
REQ-018 out_valid=1 in SEND_LO/SEND_HI, 0 in IDLE; out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous push and pop SHALL keep count unchanged and lose no row.
REQ-020 Zero-valued entries SHALL be stored and streamed like any other value.
REQ-021 Row offered while row_ready=0 SHALL be dropped and overflow_err set to 1 next cycle, held until reset.
REQ-022 Back-to-back rows SHALL stream with no idle cycle between a row's last element and next row's entry 0 when out_ready held 1.

Reset
REQ-023 While reset=1 at a clock edge: count, pointers, FSM=IDLE, out_valid=0, out_last=0, out_data=0, overflow_err=0, row_ready=0.
REQ-024 row_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-025 Reset mid-stream SHALL discard all buffered rows; no out_valid until a new row is accepted; row_valid during reset ignored, no overflow_err.

Configuration
REQ-026 Macro ACC_READER_ROWCNT_EN defined: extra port rows_sent output 8, count of fully streamed rows, +1 on each SHALL-REQ-017 pop, wraps 255->0, reset to 0.
REQ-027 Macro ACC_READER_ROWCNT_EN undefined: rows_sent port and counter absent; all other behaviour identical.

Verification
REQ-028 Single row 0x12/0x34, out_ready=1 -> out_valid next cycle; outputs 0x12 (last=0), 0x34 (last=1); then IDLE.
REQ-029 Rows A=(0x01,0x02), B=(0x03,0x04) pushed back-to-back, out_ready=1 -> stream 01,02,03,04 contiguous, last on 02 and 04.
REQ-030 out_ready=0, push DEPTH=2 rows -> row_ready=0; third row 0xAA/0xBB -> dropped, overflow_err=1 sticky; release out_ready -> only first two rows out.
REQ-031 out_ready toggled 1,0,1,0 during row (0x00,0xFF) -> out_data held during stalls; 0x00 streamed, each element exactly once.
REQ-032 Reset asserted while in SEND_HI with 1 row buffered -> all outputs 0, next cycle row_ready=1, out_valid=0 until new push.
REQ-033 With ACC_READER_ROWCNT_EN, stream 257 rows -> rows_sent=1 after wrap.
